// File: rtl/uart_rx_packet_ctrl_pkg.sv
// Shared types and constants for the UART packet framing controller.
//   state_e         : framing FSM states
//   SyncByteDefault : default frame start marker
//   addr_width()    : buffer index width for a given payload capacity
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StPayload,
    StChk,
    StHold
  } state_e;

  localparam logic [7:0] SyncByteDefault = 8'hA5;

  // At least one bit wide, so that MAX_LEN == 1 still yields a legal port.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_packet_ctrl_if.sv
// Bundle between the UART byte source / host logic and the packet controller.
//   master : drives rx_data/rx_ready, pkt_ack and rd_addr; sees packet status
//   slave  : the controller itself
interface uart_rx_packet_ctrl_if
  import uart_pkt_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16
);
  localparam int unsigned AddrW = addr_width(MAX_LEN);

  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             pkt_valid;
  logic [7:0]       pkt_len;
  logic             pkt_ack;
  logic [AddrW-1:0] rd_addr;
  logic [7:0]       rd_data;
  logic             err_chk;
  logic             err_len;
  logic             err_timeout;
  logic             err_overrun;

  modport master (
    output rx_data, rx_ready, pkt_ack, rd_addr,
    input  pkt_valid, pkt_len, rd_data, err_chk, err_len, err_timeout, err_overrun
  );

  modport slave (
    input  rx_data, rx_ready, pkt_ack, rd_addr,
    output pkt_valid, pkt_len, rd_data, err_chk, err_len, err_timeout, err_overrun
  );

endinterface

// File: rtl/uart_rx_packet_ctrl_pkt_buffer.sv
// Payload store: Depth x 8 register array, one synchronous write port and a
// registered read port (one cycle latency). Contents are not reset.
//   clk, reset : clock, asynchronous active-high reset (read register only)
//   we_i, wr_addr_i, wr_data_i : write port
//   rd_addr_i, rd_data_o       : read port
module pkt_buffer #(
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [7:0]       wr_data_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [7:0]       rd_data_o
);

  logic [7:0] mem_q [Depth];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Addresses past Depth (non power-of-two sizes) read as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= 8'h00;
    end else if (32'(rd_addr_i) < Depth) begin
      rd_data_q <= mem_q[rd_addr_i];
    end else begin
      rd_data_q <= 8'h00;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_rx_packet_ctrl.sv
// Framing controller behind a UART receiver: hunts for SYNC, captures a
// length-prefixed payload, verifies an 8-bit additive checksum, enforces an
// inter-byte timeout and holds a good packet until the host acks it.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of uart_rx_packet_ctrl_if (byte input, packet
//                status, ack, buffer read port, error pulses)
module uart_rx_packet_ctrl
  import uart_pkt_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = SyncByteDefault,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 100
) (
  input logic                  clk,
  input logic                  reset,
  uart_rx_packet_ctrl_if.slave bus
);

  localparam int unsigned    AddrW   = addr_width(MAX_LEN);
  localparam int unsigned    TmoW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]     MaxLenB = 8'(MAX_LEN);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  state_e          state_q;
  logic [7:0]      len_q;
  logic [7:0]      sum_q;
  logic [7:0]      idx_q;
  logic [TmoW-1:0] tmo_q;
  logic            pkt_valid_q;
  logic [7:0]      pkt_len_q;
  logic            err_chk_q;
  logic            err_len_q;
  logic            err_timeout_q;
  logic            err_overrun_q;

  logic active;
  logic tmo_hit;
  logic buf_we;

  always_comb begin
    active  = (state_q == StLen) || (state_q == StPayload) || (state_q == StChk);
    // Fires on the TIMEOUT_CYC-th consecutive idle clock inside a frame.
    tmo_hit = active && !bus.rx_ready && (tmo_q == TmoLast);
    buf_we  = (state_q == StPayload) && bus.rx_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      len_q         <= 8'h00;
      sum_q         <= 8'h00;
      idx_q         <= 8'h00;
      tmo_q         <= '0;
      pkt_valid_q   <= 1'b0;
      pkt_len_q     <= 8'h00;
      err_chk_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      err_chk_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;

      if (!active || bus.rx_ready || tmo_hit) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end

      if (tmo_hit) begin
        err_timeout_q <= 1'b1;
        state_q       <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.rx_ready && (bus.rx_data == SYNC_BYTE)) begin
              state_q <= StLen;
            end
          end
          StLen: begin
            if (bus.rx_ready) begin
              sum_q <= bus.rx_data;
              idx_q <= 8'h00;
              if (bus.rx_data > MaxLenB) begin
                err_len_q <= 1'b1;
                state_q   <= StIdle;
              end else begin
                len_q   <= bus.rx_data;
                state_q <= (bus.rx_data == 8'h00) ? StChk : StPayload;
              end
            end
          end
          StPayload: begin
            if (bus.rx_ready) begin
              sum_q <= sum_q + bus.rx_data;
              idx_q <= idx_q + 8'd1;
              if (idx_q == len_q - 8'd1) begin
                state_q <= StChk;
              end
            end
          end
          StChk: begin
            if (bus.rx_ready) begin
              if (8'(sum_q + bus.rx_data) == 8'h00) begin
                pkt_valid_q <= 1'b1;
                pkt_len_q   <= len_q;
                state_q     <= StHold;
              end else begin
                err_chk_q <= 1'b1;
                state_q   <= StIdle;
              end
            end
          end
          StHold: begin
            // Bytes arriving while a packet is held are dropped, even in
            // the cycle the host acks.
            if (bus.rx_ready) begin
              err_overrun_q <= 1'b1;
            end
            if (bus.pkt_ack) begin
              pkt_valid_q <= 1'b0;
              state_q     <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  pkt_buffer #(
    .Depth (MAX_LEN),
    .AddrW (AddrW)
  ) u_pkt_buffer (
    .clk       (clk),
    .reset     (reset),
    .we_i      (buf_we),
    .wr_addr_i (idx_q[AddrW-1:0]),
    .wr_data_i (bus.rx_data),
    .rd_addr_i (bus.rd_addr),
    .rd_data_o (bus.rd_data)
  );

  assign bus.pkt_valid   = pkt_valid_q;
  assign bus.pkt_len     = pkt_len_q;
  assign bus.err_chk     = err_chk_q;
  assign bus.err_len     = err_len_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Directed bench for uart_rx_packet_ctrl (MAX_LEN=16, TIMEOUT_CYC=100).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_uart_rx_packet_ctrl;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;
  int   seen;

  uart_rx_packet_ctrl_if #(.MAX_LEN(16)) bus ();

  uart_rx_packet_ctrl #(
    .SYNC_BYTE   (8'hA5),
    .MAX_LEN     (16),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
  endtask

  function automatic logic [3:0] errs();
    return {bus.err_chk, bus.err_len, bus.err_timeout, bus.err_overrun};
  endfunction

  task automatic ack();
    bus.pkt_ack = 1'b1;
    tick();
    bus.pkt_ack = 1'b0;
  endtask

  initial begin
    n_total      = 0;
    n_pass       = 0;
    reset        = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_ready = 1'b0;
    bus.pkt_ack  = 1'b0;
    bus.rd_addr  = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_valid", 32'(bus.pkt_valid), 32'h0);
    chk("rst_len", 32'(bus.pkt_len), 32'h0);
    chk("rst_rdata", 32'(bus.rd_data), 32'h0);
    chk("rst_errs", 32'(errs()), 32'h0);
    reset = 1'b0;
    tick();

    // Good frame A5 02 11 22 CB
    send(8'hA5); send(8'h02); send(8'h11); send(8'h22);
    chk("good_prevalid", 32'(bus.pkt_valid), 32'h0);
    send(8'hCB);
    chk("good_valid", 32'(bus.pkt_valid), 32'h1);
    chk("good_len", 32'(bus.pkt_len), 32'h2);
    chk("good_errs", 32'(errs()), 32'h0);
    bus.rd_addr = 4'd0; tick();
    chk("good_rd0", 32'(bus.rd_data), 32'h11);
    bus.rd_addr = 4'd1; tick();
    chk("good_rd1", 32'(bus.rd_data), 32'h22);

    // Overrun while held
    send(8'h55);
    chk("ovr_pulse", 32'(bus.err_overrun), 32'h1);
    chk("ovr_still_valid", 32'(bus.pkt_valid), 32'h1);
    bus.rd_addr = 4'd0; tick();
    chk("ovr_pulse_end", 32'(bus.err_overrun), 32'h0);
    chk("ovr_rd0", 32'(bus.rd_data), 32'h11);
    ack();
    chk("ack_valid_low", 32'(bus.pkt_valid), 32'h0);

    // Bad checksum, then good frame A5 01 33 CC
    send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'hCC);
    chk("bad_chk_pulse", 32'(bus.err_chk), 32'h1);
    chk("bad_valid", 32'(bus.pkt_valid), 32'h0);
    tick();
    chk("bad_chk_end", 32'(bus.err_chk), 32'h0);
    send(8'hA5); send(8'h01); send(8'h33); send(8'hCC);
    chk("after_bad_valid", 32'(bus.pkt_valid), 32'h1);
    chk("after_bad_len", 32'(bus.pkt_len), 32'h1);
    tick();
    chk("after_bad_rd0", 32'(bus.rd_data), 32'h33);
    ack();

    // Oversize length, stray 00, then zero-length frame A5 00 00
    send(8'hA5); send(8'h11);
    chk("len_pulse", 32'(bus.err_len), 32'h1);
    send(8'h00);
    chk("len_end_errs", 32'(errs()), 32'h0);
    chk("len_idle_valid", 32'(bus.pkt_valid), 32'h0);
    send(8'hA5); send(8'h00); send(8'h00);
    chk("zero_valid", 32'(bus.pkt_valid), 32'h1);
    chk("zero_len", 32'(bus.pkt_len), 32'h0);
    chk("zero_errs", 32'(errs()), 32'h0);
    ack();

    // Timeout after A5 03 44: pulse on the 100th idle clock, once only
    send(8'hA5); send(8'h03); send(8'h44);
    seen = 0;
    for (int i = 0; i < 99; i++) begin
      tick();
      if (bus.err_timeout) seen++;
    end
    chk("tmo_early", 32'(seen), 32'h0);
    tick();
    chk("tmo_fire", 32'(bus.err_timeout), 32'h1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.err_timeout) seen++;
    end
    chk("tmo_once", 32'(seen), 32'h0);
    send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'hCB);
    chk("tmo_next_valid", 32'(bus.pkt_valid), 32'h1);
    chk("tmo_next_len", 32'(bus.pkt_len), 32'h2);
    ack();

    // Reset during payload of A5 04 01 02 ..
    bus.rd_addr = 4'd0;
    send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
    chk("mid_rd0", 32'(bus.rd_data), 32'h01);
    reset = 1'b1;
    #1;
    chk("mid_rst_rdata", 32'(bus.rd_data), 32'h0);
    chk("mid_rst_valid", 32'(bus.pkt_valid), 32'h0);
    chk("mid_rst_errs", 32'(errs()), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    send(8'hA5); send(8'h03); send(8'h10); send(8'h20); send(8'h30); send(8'h9D);
    chk("post_rst_valid", 32'(bus.pkt_valid), 32'h1);
    chk("post_rst_len", 32'(bus.pkt_len), 32'h3);
    bus.rd_addr = 4'd2; tick();
    chk("post_rst_rd2", 32'(bus.rd_data), 32'h30);

    // Ack and byte in the same cycle: byte dropped with overrun, packet released
    bus.pkt_ack  = 1'b1;
    bus.rx_data  = 8'h77;
    bus.rx_ready = 1'b1;
    tick();
    bus.pkt_ack  = 1'b0;
    bus.rx_ready = 1'b0;
    chk("ack_ovr_pulse", 32'(bus.err_overrun), 32'h1);
    chk("ack_ovr_valid", 32'(bus.pkt_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
